// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that merges NREQ valid/ready requester streams into one
// write port of a shared synchronous FIFO. A winner keeps the port for up to
// BURST words. It loses the port early if it drops valid. Every release is
// followed by one IDLE cycle in which the next owner is chosen. A
// per-requester counter tallies the words that were accepted.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   clr_i        synchronous clear of state, pointer and counters
//   req_valid_i  [NREQ]        requester n has a word
//   req_data_i   [NREQ*WIDTH]  word of requester n at [n*WIDTH +: WIDTH]
//   req_ready_o  [NREQ]        word of requester n accepted when valid&ready
//   fifo_wr_o                  write strobe to shared FIFO
//   fifo_data_o  [WIDTH]       write data to shared FIFO
//   fifo_full_i                shared FIFO full
//   grant_o      [NREQ]        one-hot current owner, zero when idle
//   busy_o                     high while a requester owns the port
//   cnt_o        [NREQ*CNT_W]  accepted-word count of requester n
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int BURST = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ*WIDTH-1:0]   req_data_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic                    fifo_wr_o,
    output logic [WIDTH-1:0]        fifo_data_o,
    input  logic                    fifo_full_i,
    output logic [NREQ-1:0]         grant_o,
    output logic                    busy_o,
    output logic [NREQ*CNT_W-1:0]   cnt_o
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(BURST + 1);
    localparam logic [LW-1:0] LAST_RST   = LW'(NREQ - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
    localparam logic [LW:0]   NREQ_W     = (LW + 1)'(NREQ);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e             state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic [LW-1:0]      last_q, last_d;
    logic [CNT_W-1:0]   cnt_q [NREQ];
    logic [CNT_W-1:0]   cnt_d [NREQ];

    logic [LW-1:0]      gidx;
    logic [LW-1:0]      winner;
    logic               found;
    logic [LW:0]        idx_w;
    logic               valid_g;
    logic               transfer;

    // Binary index of the current owner, used to steer data and counters.
    always_comb begin
        gidx = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (grant_q[n]) begin
                gidx = LW'(n);
            end
        end
    end

    // Round-robin search starting just after the previous owner. The sum is
    // one bit wider so the modulo works for non-power-of-two NREQ.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        idx_w  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx_w = {1'b0, last_q} + (LW + 1)'(i);
            if (idx_w >= NREQ_W) begin
                idx_w = idx_w - NREQ_W;
            end
            if (!found && req_valid_i[idx_w[LW-1:0]]) begin
                found  = 1'b1;
                winner = idx_w[LW-1:0];
            end
        end
    end

    // clr_i suppresses the handshake in its own cycle, so no word is lost
    // between being accepted and the counters being wiped.
    always_comb begin
        req_ready_o = '0;
        if (state_q == GRANT && !fifo_full_i && !clr_i) begin
            req_ready_o = grant_q;
        end
    end

    assign valid_g   = |(req_valid_i & grant_q);
    assign transfer  = |(req_valid_i & req_ready_o);
    assign fifo_wr_o = transfer;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q == GRANT);

    always_comb begin
        fifo_data_o = '0;
        if (state_q == GRANT) begin
            fifo_data_o = req_data_i[int'(gidx)*WIDTH +: WIDTH];
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
        assign cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        last_d  = last_q;
        for (int n = 0; n < NREQ; n++) begin
            cnt_d[n] = cnt_q[n];
        end

        if (clr_i) begin
            state_d = IDLE;
            grant_d = '0;
            burst_d = '0;
            last_d  = LAST_RST;
            for (int n = 0; n < NREQ; n++) begin
                cnt_d[n] = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req_valid_i) begin
                        state_d = GRANT;
                        grant_d = {{(NREQ-1){1'b0}}, 1'b1} << winner;
                        last_d  = winner;
                        burst_d = '0;
                    end
                end
                GRANT: begin
                    // Withdrawal releases the port even under backpressure.
                    if (!valid_g) begin
                        state_d = IDLE;
                        grant_d = '0;
                        burst_d = '0;
                    end else if (transfer) begin
                        cnt_d[gidx] = cnt_q[gidx] + CNT_W'(1);
                        if (burst_q == BURST_LAST) begin
                            state_d = IDLE;
                            grant_d = '0;
                            burst_d = '0;
                        end else begin
                            burst_d = burst_q + BW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            burst_q <= '0;
            last_q  <= LAST_RST;
            for (int n = 0; n < NREQ; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            for (int n = 0; n < NREQ; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Bench for fifo_wr_arbiter (NREQ=4, BURST=4, CNT_W=4 so counters wrap).
// Inputs change on the falling edge. Outputs are checked 1 ns later against
// a behavioural owner/word-count model. The model state then moves on to
// what the next rising edge must produce. Each requester sends the word
// {index, sequence}. A scoreboard checks that the FIFO sees each requester's
// sequence in order with nothing lost or repeated. Directed scenarios pin
// the model to hand-computed cycle numbers, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int BURST = 4;
    localparam int CNT_W = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   clr_i = 1'b0;
    logic [NREQ-1:0]        req_valid_i = '0;
    logic [NREQ*WIDTH-1:0]  req_data_i = '0;
    logic [NREQ-1:0]        req_ready_o;
    logic                   fifo_wr_o;
    logic [WIDTH-1:0]       fifo_data_o;
    logic                   fifo_full_i = 1'b0;
    logic [NREQ-1:0]        grant_o;
    logic                   busy_o;
    logic [NREQ*CNT_W-1:0]  cnt_o;

    fifo_wr_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST), .CNT_W(CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (clr_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .fifo_wr_o   (fifo_wr_o),
        .fifo_data_o (fifo_data_o),
        .fifo_full_i (fifo_full_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .cnt_o       (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner (-1 = nobody), words in current burst,
    // previous owner, word counts.
    int          own;
    int          words;
    int          last;
    int          mcnt [NREQ];
    logic [23:0] seq  [NREQ];
    logic [23:0] rx   [NREQ];

    int          cyc;
    logic [3:0]  hist_grant [64];
    logic        hist_wr    [64];
    logic [15:0] hist_cnt   [64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [NREQ-1:0] v, input logic f, input logic c, input logic r);
        logic [NREQ-1:0]       e_grant;
        logic [NREQ-1:0]       e_ready;
        logic                  e_wr;
        logic [WIDTH-1:0]      e_data;
        logic [NREQ*CNT_W-1:0] e_cnt;
        int                    src;
        @(negedge clk_i);
        req_valid_i = v;
        fifo_full_i = f;
        clr_i       = c;
        rst_i       = r;
        for (int n = 0; n < NREQ; n++) begin
            req_data_i[n*WIDTH +: WIDTH] = {8'(n), seq[n]};
        end
        #1;
        if (r) begin
            own = -1;
            words = 0;
            last = NREQ - 1;
            for (int n = 0; n < NREQ; n++) mcnt[n] = 0;
        end
        e_grant = '0;
        e_ready = '0;
        e_wr    = 1'b0;
        e_data  = '0;
        if (own >= 0) begin
            e_grant[own] = 1'b1;
            e_data = {8'(own), seq[own]};
            if (!c && !f) e_ready = e_grant;
            e_wr = v[own] && e_ready[own];
        end
        for (int n = 0; n < NREQ; n++) e_cnt[n*CNT_W +: CNT_W] = CNT_W'(mcnt[n]);

        chk("grant", 64'(grant_o), 64'(e_grant));
        chk("busy", 64'(busy_o), 64'(own >= 0));
        chk("ready", 64'(req_ready_o), 64'(e_ready));
        chk("fifo_wr", 64'(fifo_wr_o), 64'(e_wr));
        chk("fifo_data", 64'(fifo_data_o), 64'(e_data));
        chk("cnt", 64'(cnt_o), 64'(e_cnt));
        if (fifo_wr_o) begin
            src = int'(fifo_data_o[31:24]);
            if (src < NREQ) begin
                chk("sb_seq", 64'(fifo_data_o[23:0]), 64'(rx[src]));
                rx[src] = rx[src] + 24'd1;
            end else begin
                chk("sb_src", 64'(src), 64'(NREQ - 1));
            end
        end
        if (cyc < 64) begin
            hist_grant[cyc] = grant_o;
            hist_wr[cyc]    = fifo_wr_o;
            hist_cnt[cyc]   = 16'(cnt_o);
        end
        cyc++;

        // What the next rising edge must produce.
        if (r) begin
            // already at reset values
        end else if (c) begin
            own = -1;
            words = 0;
            last = NREQ - 1;
            for (int n = 0; n < NREQ; n++) mcnt[n] = 0;
        end else if (own < 0) begin
            for (int i = 1; i <= NREQ; i++) begin
                if (own < 0 && v[(last + i) % NREQ]) own = (last + i) % NREQ;
            end
            if (own >= 0) begin
                last = own;
                words = 0;
            end
        end else if (!v[own]) begin
            own = -1;
        end else if (e_wr) begin
            mcnt[own] = (mcnt[own] + 1) % (1 << CNT_W);
            seq[own] = seq[own] + 24'd1;
            words++;
            if (words == BURST) own = -1;
        end
    endtask

    task automatic do_reset();
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);
        cyc = 0;
    endtask

    logic [7:0]      wr_vec;
    logic [NREQ-1:0] vcur;

    initial begin
        own = -1;
        words = 0;
        last = NREQ - 1;
        cyc = 0;
        for (int n = 0; n < NREQ; n++) begin
            mcnt[n] = 0;
            seq[n]  = 24'(n * 4096);
            rx[n]   = 24'(n * 4096);
        end

        // Single requester 2, six words: writes in cycles 1-4 and 6-7.
        do_reset();
        chk("rst_grant", 64'(grant_o), 64'h0);
        chk("rst_cnt", 64'(cnt_o), 64'h0);
        for (int k = 0; k < 8; k++) step(4'b0100, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) wr_vec[k] = hist_wr[k];
        chk("s1_wr_pattern", 64'(wr_vec), 64'hDE);
        chk("s1_grant_c1", 64'(hist_grant[1]), 64'h4);
        chk("s1_bubble_c5", 64'(hist_grant[5]), 64'h0);
        chk("s1_cnt2", 64'(hist_cnt[8][11:8]), 64'd6);

        // All four valid: order 0,1,2,3,0 with five-cycle spacing.
        do_reset();
        for (int k = 0; k < 22; k++) step(4'b1111, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("s2_grant_c1", 64'(hist_grant[1]), 64'h1);
        chk("s2_grant_c6", 64'(hist_grant[6]), 64'h2);
        chk("s2_grant_c11", 64'(hist_grant[11]), 64'h4);
        chk("s2_grant_c16", 64'(hist_grant[16]), 64'h8);
        chk("s2_grant_c21", 64'(hist_grant[21]), 64'h1);
        chk("s2_cnt_c20", 64'(hist_cnt[20]), 64'h4444);

        // Backpressure on requester 1 for cycles 3-5.
        do_reset();
        for (int k = 0; k < 8; k++) step(4'b0010, (k >= 3 && k <= 5), 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) wr_vec[k] = hist_wr[k];
        chk("s3_wr_pattern", 64'(wr_vec), 64'hC6);
        chk("s3_grant_held", 64'(hist_grant[4]), 64'h2);
        chk("s3_cnt1", 64'(hist_cnt[8][7:4]), 64'd4);

        // Requester 0 withdraws after two words; requester 1 follows.
        do_reset();
        for (int k = 0; k < 3; k++) step(4'b0011, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(4'b0010, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("s4_idle_c4", 64'(hist_grant[4]), 64'h0);
        chk("s4_grant_c5", 64'(hist_grant[5]), 64'h2);
        chk("s4_cnt0", 64'(hist_cnt[4][3:0]), 64'd2);

        // Clear while requester 3 owns the port with five words counted.
        do_reset();
        for (int k = 0; k < 7; k++) step(4'b1000, 1'b0, 1'b0, 1'b0);
        step(4'b1001, 1'b0, 1'b1, 1'b0);
        step(4'b1001, 1'b0, 1'b0, 1'b0);
        step(4'b1001, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("s5_cnt3_pre", 64'(hist_cnt[7][15:12]), 64'd5);
        chk("s5_no_wr_clr", 64'(hist_wr[7]), 64'd0);
        chk("s5_grant_c8", 64'(hist_grant[8]), 64'h0);
        chk("s5_cnt_c8", 64'(hist_cnt[8]), 64'h0);
        chk("s5_grant_c9", 64'(hist_grant[9]), 64'h1);

        // 17 words from requester 0 with a 4-bit counter.
        do_reset();
        for (int k = 0; k < 22; k++) step(4'b0001, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("s6_cnt0_wrap", 64'(hist_cnt[22][3:0]), 64'd1);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        step(4'b0111, 1'b0, 1'b0, 1'b0);
        step(4'b0111, 1'b0, 1'b0, 1'b0);
        step(4'b0111, 1'b0, 1'b0, 1'b1);
        step(4'b0111, 1'b0, 1'b0, 1'b0);
        step(4'b0111, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("s7_wr_c1", 64'(hist_wr[1]), 64'd1);
        chk("s7_rst_no_wr", 64'(hist_wr[2]), 64'd0);
        chk("s7_rst_grant", 64'(hist_grant[2]), 64'h0);
        chk("s7_regrant_c4", 64'(hist_grant[4]), 64'h1);

        // Randomized traffic.
        vcur = '0;
        for (int k = 0; k < 4000; k++) begin
            for (int n = 0; n < NREQ; n++) begin
                if ($urandom_range(0, 4) == 0) vcur[n] = ~vcur[n];
            end
            step(vcur,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 399) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, data word width.
REQ-002 Parameter: NREQ, 4, number of requester ports (2..8).
REQ-003 Parameter: BURST, 4, max transfers per grant (1..16).
REQ-004 Parameter: CNT_W, 16, per-requester word counter width.
REQ-005 Port: clk_i  in  1  clock; all logic on rising edge.
REQ-006 Port: rst_i  in  1  reset, asynchronous, active-high.
REQ-007 Port: clr_i  in  1  synchronous clear, active-high.
REQ-008 Port: req_valid_i  in  NREQ  requester n has a word.
REQ-009 Port: req_data_i  in  NREQ*WIDTH  requester n word at bits [n*WIDTH +: WIDTH].
REQ-010 Port: req_ready_o  out  NREQ  word of requester n accepted this cycle when valid&ready.
REQ-011 Port: fifo_wr_o  out  1  write strobe to shared sync FIFO.
REQ-012 Port: fifo_data_o  out  WIDTH  write data to shared FIFO.
REQ-013 Port: fifo_full_i  in  1  shared FIFO full.
REQ-014 Port: grant_o  out  NREQ  one-hot current owner; all-zero when idle.
REQ-015 Port: busy_o  out  1  high in GRANT state.
REQ-016 Port: cnt_o  out  NREQ*CNT_W  accepted-word count per requester, at [n*CNT_W +: CNT_W].

Function
REQ-017 Two states: IDLE, GRANT; state, grant_o, burst counter, RR pointer last_q, counters are registers.
REQ-018 IDLE: if any req_valid_i, select first valid requester searching last_q+1, last_q+2, ... mod NREQ; next cycle state=GRANT, grant_o=one-hot of winner, last_q=winner, burst count=0.
REQ-019 IDLE with no req_valid_i: remain IDLE, grant_o=0, last_q unchanged.
REQ-020 req_ready_o[n] = (state==GRANT) & grant_o[n] & !fifo_full_i, combinational; all other bits 0.
REQ-021 Transfer = req_valid_i[g] & req_ready_o[g]; fifo_wr_o = transfer, combinational, same cycle.
REQ-022 fifo_data_o = req_data_i of granted requester while GRANT; 0 in IDLE.
REQ-023 fifo_wr_o never asserts while fifo_full_i=1.
REQ-024 Each transfer increments burst count and cnt_o[g] by 1; cnt_o wraps 2^CNT_W-1 -> 0.
REQ-025 GRANT -> IDLE next cycle when transfer occurs with burst count == BURST-1 (BURST-th word).
REQ-026 GRANT -> IDLE next cycle when req_valid_i[g]=0 (requester withdrew), regardless of fifo_full_i.
REQ-027 GRANT with req_valid_i[g]=1 and fifo_full_i=1: hold grant, no transfer, burst count unchanged, no timeout.
REQ-028 One arbitration bubble after every release: max throughput BURST/(BURST+1) words/cycle.
REQ-029 Non-granted requesters' req_valid_i changes have no effect during GRANT.
REQ-030 Requester may drop valid without ready (no lock); arbiter imposes no data ordering across requesters.
REQ-031 clr_i (priority below rst_i, above all else): state=IDLE, grant_o=0, burst count=0, last_q=NREQ-1, all cnt_o=0; no transfer that cycle (req_ready_o=0, fifo_wr_o=0).

Reset
REQ-032 On rst_i: state=IDLE, grant_o=0, busy_o=0, burst count=0, last_q=NREQ-1, cnt_o=0, req_ready_o=0, fifo_wr_o=0, fifo_data_o=0.
REQ-033 rst_i mid-GRANT aborts immediately; no fifo_wr_o while rst_i high; after release requester 0 has highest priority.

Verification
REQ-034 Single requester: req 2 valid continuously, 6 words, full=0 -> grant cycle 1, words 0-3 written cycles 1-4, bubble cycle 5, words 4-5 cycles 6-7, cnt_o[2]=6.
REQ-035 Round robin: all 4 valid continuously after reset, BURST=4 -> grant order 0,1,2,3,0; each burst 4 writes; cnt_o each =4 after 20 cycles.
REQ-036 Backpressure: req 1 granted, fifo_full_i=1 for 3 cycles mid-burst -> fifo_wr_o=0 and ready=0 those cycles, grant held, burst resumes, total 4 words, no data lost/duplicated.
REQ-037 Withdrawal: req 0 granted, valid drops after 2 words -> IDLE next cycle, next valid requester (1) granted, cnt_o[0]=2.
REQ-038 clr_i during GRANT of req 3 with cnt_o[3]=5 -> same cycle no write; next cycle grant_o=0, cnt_o all 0, next grant goes to lowest valid index.
REQ-039 Counter wrap: CNT_W=4, 17 words from req 0 -> cnt_o[0]=1; scoreboard confirms FIFO data equals per-requester sent sequence.
